// File: rtl/debouncer_multi_sync.sv
// Multi-channel debouncer: each noisy_in bit is synchronised through a flop chain,
// then accepted as the new level only after num_delay_clks consecutive differing cycles.
module debouncer_multi_sync #(
    parameter int num_ch         = 4,
    parameter int num_stages     = 2,
    parameter int num_delay_clks = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [num_ch-1:0] noisy_in,
    output logic [num_ch-1:0] debouncer_out,
    output logic [num_ch-1:0] rise_pulse,
    output logic [num_ch-1:0] fall_pulse,
    output logic              any_change
);

    localparam int cnt_w = $clog2(num_delay_clks);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(num_delay_clks - 1);

    logic [num_stages-1:0][num_ch-1:0] sync_q, sync_d;
    logic [num_ch-1:0]                 sync_val;
    logic [cnt_w-1:0]                  cnt_q [num_ch];
    logic [cnt_w-1:0]                  cnt_d [num_ch];
    logic [num_ch-1:0]                 out_q, out_d;
    logic [num_ch-1:0]                 rise_q, rise_d;
    logic [num_ch-1:0]                 fall_q, fall_d;
    logic                              any_q, any_d;

    // Stage 0 captures the raw input; the last stage feeds the stability counters.
    assign sync_val = sync_q[num_stages-1];

    always_comb begin
        sync_d = {sync_q[num_stages-2:0], noisy_in};
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        if (en) begin
            for (int i = 0; i < num_ch; i++) begin
                if (sync_val[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == cnt_last) begin
                    cnt_d[i]  = '0;
                    out_d[i]  = sync_val[i];
                    rise_d[i] = sync_val[i];
                    fall_d[i] = ~sync_val[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + cnt_w'(1);
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            for (int i = 0; i < num_ch; i++) begin
                cnt_q[i] <= '0;
            end
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
        end
    end

    assign debouncer_out = out_q;
    assign rise_pulse    = rise_q;
    assign fall_pulse    = fall_q;
    assign any_change    = any_q;

endmodule

// File: tb/tb_debouncer_multi_sync.sv
// Bench for debouncer_multi_sync: directed edge-exact scenarios on a short-delay
// instance, plus a randomized soak of a 100-cycle instance against a window model.
module tb_debouncer_multi_sync;

    logic       clk;
    logic       rst, en;
    logic [3:0] noisy;
    logic [3:0] dout, rise, fall;
    logic       any;

    logic       s_rst, s_en;
    logic [3:0] s_noisy;
    logic [3:0] s_dout, s_rise, s_fall;
    logic       s_any;

    int n_cmp;
    int n_err;

    debouncer_multi_sync #(.num_ch(4), .num_stages(2), .num_delay_clks(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .noisy_in(noisy),
        .debouncer_out(dout), .rise_pulse(rise), .fall_pulse(fall), .any_change(any)
    );

    debouncer_multi_sync #(.num_ch(4), .num_stages(2), .num_delay_clks(100)) u_soak (
        .clk(clk), .rst(s_rst), .en(s_en), .noisy_in(s_noisy),
        .debouncer_out(s_dout), .rise_pulse(s_rise), .fall_pulse(s_fall), .any_change(s_any)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] val);
        rst   = 1'b1;
        en    = 1'b1;
        noisy = val;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] e_out, e_rise;
        rst   = 1'b1;
        en    = 1'b1;
        noisy = 4'hF;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if ({dout, rise, fall, any} !== 13'h0) begin
                n_err++;
                $display("FAIL reset_hold k=%0d: got out=%h rise=%h fall=%h any=%b want all 0", k, dout, rise, fall, any);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            e_out  = (k >= 6) ? 4'hF : 4'h0;
            e_rise = (k == 6) ? 4'hF : 4'h0;
            n_cmp++;
            if ({dout, rise, fall, any} !== {e_out, e_rise, 4'h0, (k == 6)}) begin
                n_err++;
                $display("FAIL reset_release edge=%0d: got out=%h rise=%h fall=%h any=%b want out=%h rise=%h fall=0 any=%b",
                         k, dout, rise, fall, any, e_out, e_rise, (k == 6));
            end
        end
    endtask

    task automatic test_clean_step;
        logic [3:0] e_out, e_rise;
        do_reset(4'h0);
        noisy = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            e_out  = (k >= 6) ? 4'h1 : 4'h0;
            e_rise = (k == 6) ? 4'h1 : 4'h0;
            n_cmp++;
            if ({dout, rise, fall, any} !== {e_out, e_rise, 4'h0, (k == 6)}) begin
                n_err++;
                $display("FAIL clean_step edge=%0d: got out=%h rise=%h fall=%h any=%b want out=%h rise=%h",
                         k, dout, rise, fall, any, e_out, e_rise);
            end
        end
    endtask

    task automatic test_glitch_reject;
        logic [3:0] e_out, e_rise;
        do_reset(4'h0);
        noisy = 4'h2;
        repeat (3) tick();
        noisy = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if ({dout, rise, fall, any} !== 13'h0) begin
                n_err++;
                $display("FAIL glitch_hold k=%0d: got out=%h rise=%h fall=%h any=%b want all 0", k, dout, rise, fall, any);
            end
        end
        noisy = 4'h2;
        for (int k = 1; k <= 7; k++) begin
            tick();
            e_out  = (k >= 6) ? 4'h2 : 4'h0;
            e_rise = (k == 6) ? 4'h2 : 4'h0;
            n_cmp++;
            if ({dout, rise, fall, any} !== {e_out, e_rise, 4'h0, (k == 6)}) begin
                n_err++;
                $display("FAIL glitch_stable edge=%0d: got out=%h rise=%h want out=%h rise=%h", k, dout, rise, e_out, e_rise);
            end
        end
    endtask

    task automatic test_bounce_train;
        logic [3:0] e_out, e_fall;
        int         n_fall;
        n_fall = 0;
        do_reset(4'h0);
        noisy = 4'h4;
        repeat (8) tick();
        n_cmp++;
        if (dout !== 4'h4) begin
            n_err++;
            $display("FAIL bounce_setup: got out=%h want 4", dout);
        end
        for (int k = 0; k < 20; k++) begin
            noisy = ((k / 2) % 2 != 0) ? 4'h4 : 4'h0;
            tick();
            n_cmp++;
            if ({dout, fall} !== {4'h4, 4'h0}) begin
                n_err++;
                $display("FAIL bounce_train k=%0d: got out=%h fall=%h want out=4 fall=0", k, dout, fall);
            end
        end
        noisy = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (fall[2]) n_fall++;
            e_out  = (k >= 6) ? 4'h0 : 4'h4;
            e_fall = (k == 6) ? 4'h4 : 4'h0;
            n_cmp++;
            if ({dout, rise, fall, any} !== {e_out, 4'h0, e_fall, (k == 6)}) begin
                n_err++;
                $display("FAIL bounce_settle edge=%0d: got out=%h fall=%h any=%b want out=%h fall=%h",
                         k, dout, fall, any, e_out, e_fall);
            end
        end
        n_cmp++;
        if (n_fall != 1) begin
            n_err++;
            $display("FAIL bounce_fall_count: got %0d want 1", n_fall);
        end
    endtask

    task automatic test_en_gating;
        do_reset(4'h0);
        noisy = 4'h8;
        repeat (4) tick();
        en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if ({dout, rise, fall, any} !== 13'h0) begin
                n_err++;
                $display("FAIL en_frozen k=%0d: got out=%h rise=%h fall=%h any=%b want all 0", k, dout, rise, fall, any);
            end
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if ({dout, rise} !== 8'h00) begin
            n_err++;
            $display("FAIL en_resume1: got out=%h rise=%h want out=0 rise=0", dout, rise);
        end
        tick();
        n_cmp++;
        if ({dout, rise, fall, any} !== {4'h8, 4'h8, 4'h0, 1'b1}) begin
            n_err++;
            $display("FAIL en_resume2: got out=%h rise=%h any=%b want out=8 rise=8 any=1", dout, rise, any);
        end
        tick();
        n_cmp++;
        if ({dout, rise, any} !== {4'h8, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL en_resume3: got out=%h rise=%h any=%b want out=8 rise=0 any=0", dout, rise, any);
        end
    endtask

    // Model: a channel flips once its last 100 enabled synchronised samples all
    // differ from its current level; samples are noisy_in delayed by two edges.
    task automatic test_random_soak;
        logic [3:0] pipe_q[$];
        logic [3:0] exp_q[$];
        logic [3:0] m_out, e_rise, e_fall, v, cur_sync, tgt, prev_dout;
        logic       cur_en, all_diff;
        int         since[4];
        int         flips;
        flips     = 0;
        tgt       = 4'h0;
        m_out     = 4'h0;
        prev_dout = 4'h0;
        for (int c = 0; c < 4; c++) since[c] = 100;
        s_rst   = 1'b1;
        s_en    = 1'b1;
        s_noisy = 4'h0;
        repeat (3) tick();
        n_cmp++;
        if ({s_dout, s_rise, s_fall, s_any} !== 13'h0) begin
            n_err++;
            $display("FAIL soak_reset: got out=%h rise=%h fall=%h any=%b want all 0", s_dout, s_rise, s_fall, s_any);
        end
        s_rst = 1'b0;
        pipe_q.delete();
        exp_q.delete();
        pipe_q.push_back(4'h0);
        pipe_q.push_back(4'h0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 249) == 0) begin
                    tgt[c]   = ~tgt[c];
                    since[c] = 0;
                end else begin
                    since[c]++;
                end
                v[c] = (since[c] < 40 && $urandom_range(0, 2) == 0) ? ~tgt[c] : tgt[c];
            end
            s_noisy = v;
            cur_en  = ($urandom_range(0, 15) != 0);
            s_en    = cur_en;
            tick();
            cur_sync = pipe_q.pop_front();
            pipe_q.push_back(v);
            e_rise = 4'h0;
            e_fall = 4'h0;
            if (cur_en) begin
                exp_q.push_back(cur_sync);
                if (exp_q.size() > 100) void'(exp_q.pop_front());
                if (exp_q.size() == 100) begin
                    for (int c = 0; c < 4; c++) begin
                        all_diff = 1'b1;
                        foreach (exp_q[j]) if (exp_q[j][c] == m_out[c]) all_diff = 1'b0;
                        if (all_diff) begin
                            m_out[c]  = ~m_out[c];
                            e_rise[c] = m_out[c];
                            e_fall[c] = ~m_out[c];
                            flips++;
                        end
                    end
                end
            end
            n_cmp++;
            if ({s_dout, s_rise, s_fall, s_any} !== {m_out, e_rise, e_fall, |(e_rise | e_fall)}) begin
                n_err++;
                $display("FAIL soak cyc=%0d: got out=%h rise=%h fall=%h any=%b want out=%h rise=%h fall=%h any=%b",
                         cyc, s_dout, s_rise, s_fall, s_any, m_out, e_rise, e_fall, |(e_rise | e_fall));
            end
            n_cmp++;
            if ({s_rise, s_fall} !== {s_dout & ~prev_dout, ~s_dout & prev_dout}) begin
                n_err++;
                $display("FAIL soak_pulse_vs_edge cyc=%0d: got rise=%h fall=%h out=%h prev=%h", cyc, s_rise, s_fall, s_dout, prev_dout);
            end
            prev_dout = s_dout;
        end
        n_cmp++;
        if (flips < 4) begin
            n_err++;
            $display("FAIL soak_activity: got %0d model flips want at least 4", flips);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        en      = 1'b1;
        noisy   = 4'h0;
        s_rst   = 1'b1;
        s_en    = 1'b1;
        s_noisy = 4'h0;
        test_reset();
        test_clean_step();
        test_glitch_reject();
        test_bounce_train();
        test_en_gating();
        test_random_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
